huffman_decoder: RTL
====================

# huffman_decoder

Receive-side counterpart of the Huffman encoder. Latches the six-entry code table (HCn/Mn) that the encoder produces, then consumes a serial MSB-first code bitstream at up to one bit per clock. Emits the decoded gray-level symbol (1..6) for every complete codeword, flags undecodable sequences, and keeps a running symbol count. Sits downstream of the encoder and channel in the compression test path.

## Interface
- No parameters; table size fixed at 6 entries, code length at most 8 bits.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- tbl_valid  in  1  one-cycle strobe; HC1..HC6 and M1..M6 are valid this cycle.
- HC1..HC6  in  8 each  codeword, right-aligned (LSB = last transmitted bit).
- M1..M6  in  8 each  mask, 2^k-1 for code length k (1..8); 0 = entry disabled.
- bit_valid  in  1  bit_in valid this cycle.
- bit_in  in  1  next code bit, MSB of codeword first.
- bit_ready  out  1  high when a table is loaded and bits are accepted.
- sym_valid  out  1  one-cycle pulse, sym holds a decoded symbol.
- sym  out  3  decoded symbol index 1..6; holds last value otherwise.
- err  out  1  one-cycle pulse, 8 bits accumulated without a match.
- sym_count  out  8  number of symbols decoded since last table load, saturates at 255.

## Operation
- States: EMPTY (no table; reset state) and READY. EMPTY -> READY on tbl_valid. READY -> READY on tbl_valid (reload). Only reset returns to EMPTY.
- Table load: registers all 12 table inputs, clears shift register sr[7:0], length counter len[3:0] and sym_count. bit_ready = (state == READY).
- Bit accept: when bit_valid && bit_ready && !tbl_valid. Form sr_n = {sr[6:0], bit_in}, len_n = len + 1.
- Match for entry i: Mi != 0, Mi == (1 << len_n) - 1, and (sr_n & Mi) == HCi. Multiple matches (non-prefix-free table): lowest index wins.
- On match: sym <= i, sym_valid <= 1, sr <= 0, len <= 0, sym_count <= sym_count + 1 unless already 255.
- No match and len_n == 8: err <= 1, sr <= 0, len <= 0; sym unchanged, count unchanged.
- No match and len_n < 8: sr <= sr_n, len <= len_n.
- tbl_valid and bit_valid in the same cycle: table load wins, bit is dropped, any partial codeword discarded.
- bit_valid while EMPTY: ignored, no outputs.
- Table contents are not checked for consistency; a non-contiguous mask never matches.

## Timing
- Reset values: bit_ready 0, sym_valid 0, sym 0, err 0, sym_count 0; internal sr 0, len 0, table registers 0.
- Reset asserted mid-codeword: all state cleared immediately; table must be reloaded.
- bit_ready rises the cycle after the tbl_valid edge.
- Latency: sym_valid/err asserted in the cycle following the edge that samples the final bit; registered outputs, no combinational path from inputs to outputs.
- Throughput: one bit per cycle, back-to-back codewords with no bubble; sym_valid may be high on consecutive cycles (1-bit codes).
- sym_valid and err are mutually exclusive; both self-clear after one cycle.
- sym_count updates in the same cycle sym_valid is high.

## Test plan
- Table HC/M = 1: 0x01/0x01, 2: 0x01/0x03, 3: 0x00/0x07, 4: 0x03/0x0F, 5: 0x05/0x1F, 6: 0x04/0x1F; stream 1,01,000,0011,00101,00100 contiguous -> sym 1,2,3,4,5,6, one pulse each, one cycle after each last bit; sym_count = 6.
- Same table, 300 consecutive bits of 1 -> 300 sym_valid pulses on consecutive cycles, sym = 1, sym_count saturates at 255.
- Table with M3 = 0, send eight 0 bits -> no sym_valid, err pulses once after the 8th bit; next stream "1" -> sym = 1.
- Send "001", then tbl_valid with a bit_valid=1 bit_in=1 in the same cycle, then "01" -> bit dropped, partial discarded, sym = 2, sym_count = 1.
- bit_valid pulses before any table load -> bit_ready 0, no sym_valid/err; assert reset after sending "00" in READY -> all outputs 0, bit_ready 0 until reload.

Source files
------------

// File: rtl/huffman_decoder.sv
// huffman_decoder: latches a six-entry Huffman code table, then decodes a
// serial MSB-first bitstream into gray-level symbols 1..6, flags codewords
// that reach 8 bits without a match, and counts decoded symbols.
module huffman_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       tbl_valid,
  input  logic [7:0] HC1,
  input  logic [7:0] HC2,
  input  logic [7:0] HC3,
  input  logic [7:0] HC4,
  input  logic [7:0] HC5,
  input  logic [7:0] HC6,
  input  logic [7:0] M1,
  input  logic [7:0] M2,
  input  logic [7:0] M3,
  input  logic [7:0] M4,
  input  logic [7:0] M5,
  input  logic [7:0] M6,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic       bit_ready,
  output logic       sym_valid,
  output logic [2:0] sym,
  output logic       err,
  output logic [7:0] sym_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    READY = 1'b1
  } state_t;

  state_t     r_state;
  logic [7:0] r_hc [6];
  logic [7:0] r_m  [6];
  logic [7:0] r_sr;
  logic [3:0] r_len;
  logic       r_bit_ready;
  logic       r_sym_valid;
  logic [2:0] r_sym;
  logic       r_err;
  logic [7:0] r_sym_count;

  logic [7:0] w_sr_n;
  logic [3:0] w_len_n;
  logic [7:0] w_need;
  logic       w_hit;
  logic [2:0] w_idx;
  logic       w_accept;

  // Candidate shift/length after accepting bit_in, and table match search.
  // Entries are scanned from 6 down to 1 so the lowest matching index wins.
  always_comb begin
    w_sr_n   = {r_sr[6:0], bit_in};
    w_len_n  = r_len + 4'd1;
    w_need   = 8'((9'd1 << w_len_n) - 9'd1);
    w_accept = bit_valid && (r_state == READY) && !tbl_valid;
    w_hit    = 1'b0;
    w_idx    = '0;
    for (int unsigned k = 0; k < 6; k++) begin
      if ((r_m[5-k] != 8'd0) && (r_m[5-k] == w_need) &&
          ((w_sr_n & r_m[5-k]) == r_hc[5-k])) begin
        w_hit = 1'b1;
        w_idx = 3'(6 - k);
      end
    end
  end

  // Table load, bit accumulation, decode and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= EMPTY;
      for (int unsigned i = 0; i < 6; i++) begin
        r_hc[i] <= '0;
        r_m[i]  <= '0;
      end
      r_sr        <= '0;
      r_len       <= '0;
      r_bit_ready <= 1'b0;
      r_sym_valid <= 1'b0;
      r_sym       <= '0;
      r_err       <= 1'b0;
      r_sym_count <= '0;
    end else begin
      r_sym_valid <= 1'b0;
      r_err       <= 1'b0;
      if (tbl_valid) begin
        // A load in the same cycle as a bit drops the bit and any partial code.
        r_state     <= READY;
        r_bit_ready <= 1'b1;
        r_hc[0] <= HC1;  r_hc[1] <= HC2;  r_hc[2] <= HC3;
        r_hc[3] <= HC4;  r_hc[4] <= HC5;  r_hc[5] <= HC6;
        r_m[0]  <= M1;   r_m[1]  <= M2;   r_m[2]  <= M3;
        r_m[3]  <= M4;   r_m[4]  <= M5;   r_m[5]  <= M6;
        r_sr        <= '0;
        r_len       <= '0;
        r_sym_count <= '0;
      end else if (w_accept) begin
        if (w_hit) begin
          r_sym       <= w_idx;
          r_sym_valid <= 1'b1;
          r_sr        <= '0;
          r_len       <= '0;
          if (r_sym_count != 8'hFF)
            r_sym_count <= r_sym_count + 8'd1;
        end else if (w_len_n == 4'd8) begin
          r_err <= 1'b1;
          r_sr  <= '0;
          r_len <= '0;
        end else begin
          r_sr  <= w_sr_n;
          r_len <= w_len_n;
        end
      end
    end
  end

  assign bit_ready = r_bit_ready;
  assign sym_valid = r_sym_valid;
  assign sym       = r_sym;
  assign err       = r_err;
  assign sym_count = r_sym_count;

endmodule
